// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM multi-register sequencer: opcodes,
// register index width and FSM state encodings.
package lm_sm_sequencer_pkg;

   localparam logic [3:0] OP_LM     = 4'b0110;
   localparam logic [3:0] OP_SM     = 4'b0111;
   localparam int         REG_IDX_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// Decode-side / execute-side bundle of the LM/SM sequencer.
// Optional feature: LMSM_PERF_CNT_EN adds the xfer_count performance counter.
interface lm_sm_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic [15:0]       id_ir;
   logic              id_valid;
   logic [ADDR_W-1:0] base_addr;
   logic              ex_ready;
   logic              flush;
   logic              stall_id;
   logic              xfer_valid;
   logic              xfer_is_load;
   logic [2:0]        xfer_reg;
   logic [ADDR_W-1:0] xfer_addr;
   logic              is_lm1;
   logic              is_imm_zero_sm;
`ifdef LMSM_PERF_CNT_EN
   logic [15:0]       xfer_count;
`endif

   // Pipeline side: presents instructions, consumes transfers
   modport master (
      output id_ir, id_valid, base_addr, ex_ready, flush,
      input  stall_id, xfer_valid, xfer_is_load, xfer_reg, xfer_addr,
             is_lm1, is_imm_zero_sm
`ifdef LMSM_PERF_CNT_EN
      , input xfer_count
`endif
   );

   // Sequencer side
   modport slave (
      input  id_ir, id_valid, base_addr, ex_ready, flush,
      output stall_id, xfer_valid, xfer_is_load, xfer_reg, xfer_addr,
             is_lm1, is_imm_zero_sm
`ifdef LMSM_PERF_CNT_EN
      , output xfer_count
`endif
   );
endinterface

// File: rtl/lm_sm_sequencer_prio_enc.sv
// MSB-first priority encoder: mask bit REG_CNT-1 maps to index 0, so the
// lowest-numbered pending register is reported first.
module lmsm_prio_enc
   import lm_sm_sequencer_pkg::*;
#(
   parameter int REG_CNT = 8
) (
   input  logic [REG_CNT-1:0]   mask,
   output logic                 found,
   output logic [REG_IDX_W-1:0] idx
);

   // Scan from the highest index down so the lowest matching index wins
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = REG_CNT - 1; i >= 0; i--) begin
         if (mask[REG_CNT-1-i]) begin
            found = 1'b1;
            idx   = REG_IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: expands a load/store-multiple instruction into one
// register transfer per cycle and stalls decode while a sequence runs.
// Optional feature: LMSM_PERF_CNT_EN adds a 16-bit accepted-transfer counter.
module lm_sm_sequencer
   import lm_sm_sequencer_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int REG_CNT   = 8,
   parameter int ADDR_STEP = 1
) (
   input logic               clk,
   input logic               rst,
   lm_sm_sequencer_if.slave  bus
);

   state_t                 state;
   logic [REG_CNT-1:0]     mask_r;
   logic [ADDR_W-1:0]      addr_r;
   logic                   type_r;
   logic                   pulse_r;

   logic                   enc_found;
   logic [REG_IDX_W-1:0]   enc_idx;
   logic [REG_CNT-1:0]     sel_bit;
   logic [REG_CNT-1:0]     mask_nxt;
   logic [3:0]             opcode;
   logic                   is_lmsm;
   logic                   start;
   logic                   accept;
   logic                   unused_ir;

   assign opcode    = bus.id_ir[15:12];
   assign is_lmsm   = (opcode == OP_LM) || (opcode == OP_SM);
   assign start     = (state == ST_IDLE) && bus.id_valid && is_lmsm && bus.ex_ready;
   assign accept    = (state == ST_RUN) && bus.ex_ready;
   assign unused_ir = ^{bus.id_ir[11:REG_CNT], enc_found};

   lmsm_prio_enc #(.REG_CNT(REG_CNT)) u_enc (
      .mask  (mask_r),
      .found (enc_found),
      .idx   (enc_idx)
   );

   // One-hot of the register being transferred, and the mask left after it
   always_comb begin
      sel_bit = '0;
      sel_bit[REG_CNT-1-int'(enc_idx)] = 1'b1;
      mask_nxt = mask_r & ~sel_bit;
   end

   // Sequencer FSM: flush outranks start/advance; completion of SM raises the pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         mask_r  <= '0;
         addr_r  <= '0;
         type_r  <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         pulse_r <= 1'b0;
         if (bus.flush) begin
            state  <= ST_IDLE;
            mask_r <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     mask_r <= bus.id_ir[REG_CNT-1:0];
                     addr_r <= bus.base_addr;
                     type_r <= (opcode == OP_LM);
                     if (bus.id_ir[REG_CNT-1:0] != '0)
                        state <= ST_RUN;
                     else
                        pulse_r <= (opcode == OP_SM);
                  end
               end
               ST_RUN: begin
                  if (accept) begin
                     mask_r <= mask_nxt;
                     addr_r <= addr_r + ADDR_W'(ADDR_STEP);
                     if (mask_nxt == '0) begin
                        state   <= ST_IDLE;
                        pulse_r <= !type_r;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.stall_id       = (state == ST_RUN);
   assign bus.xfer_valid     = (state == ST_RUN);
   assign bus.xfer_is_load   = (state == ST_RUN) && type_r;
   assign bus.xfer_reg       = (state == ST_RUN) ? enc_idx : '0;
   assign bus.xfer_addr      = (state == ST_RUN) ? addr_r : '0;
   assign bus.is_lm1         = (state == ST_RUN) && type_r;
   assign bus.is_imm_zero_sm = pulse_r;

`ifdef LMSM_PERF_CNT_EN
   logic [15:0] cnt_r;

   // Accepted-transfer counter; survives flush, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         cnt_r <= '0;
      else if (accept && !bus.flush)
         cnt_r <= cnt_r + 16'd1;
   end

   assign bus.xfer_count = cnt_r;
`endif

endmodule
